// File: rtl/pixel_frame_controller.sv
// Frame sequencer for a pixel-sensor array: erase, expose, ramp conversion,
// then row-by-row readout over a valid/ready handshake.
module pixel_frame_controller #(
  parameter int PIXEL_BITS   = 8,
  parameter int ROWS         = 2,
  parameter int ERASE_CYCLES = 5,
  parameter int EXPOSE_BITS  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [EXPOSE_BITS-1:0] expose_time,
  output logic                   erase,
  output logic                   expose,
  output logic                   ramp,
  output logic [PIXEL_BITS-1:0]  counter,
  output logic [ROWS-1:0]        read,
  output logic                   row_valid,
  input  logic                   row_ready,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int ERASE_W = (ERASE_CYCLES > 1) ? $clog2(ERASE_CYCLES) : 1;

  localparam logic [ERASE_W-1:0]     ERASE_LAST = ERASE_W'(ERASE_CYCLES - 1);
  localparam logic [ERASE_W-1:0]     ERASE_ONE  = ERASE_W'(1);
  localparam logic [EXPOSE_BITS-1:0] EXP_ONE    = EXPOSE_BITS'(1);
  localparam logic [PIXEL_BITS-1:0]  CNT_MAX    = {PIXEL_BITS{1'b1}};
  localparam logic [PIXEL_BITS-1:0]  CNT_ONE    = PIXEL_BITS'(1);
  localparam logic [ROW_W-1:0]       ROW_LAST   = ROW_W'(ROWS - 1);
  localparam logic [ROW_W-1:0]       ROW_ONE    = ROW_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ERASE      = 3'd1,
    ST_EXPOSE     = 3'd2,
    ST_CONVERT    = 3'd3,
    ST_READ_SETUP = 3'd4,
    ST_READ_VALID = 3'd5
  } state_t;

  state_t                 state_r, state_nx_s;
  logic [ERASE_W-1:0]     erase_cnt_r, erase_cnt_nx_s;
  logic [EXPOSE_BITS-1:0] expose_len_r, expose_len_nx_s;
  logic [EXPOSE_BITS-1:0] expose_cnt_r, expose_cnt_nx_s;
  logic [PIXEL_BITS-1:0]  counter_r, counter_nx_s;
  logic [ROW_W-1:0]       row_r, row_nx_s;
  logic [ROWS-1:0]        read_r, read_nx_s;
  logic                   erase_r, expose_r, ramp_r, row_valid_r, busy_r, frame_done_r;
  logic                   frame_done_nx_s, rd_active_s;

  // Next-state and phase counters
  always_comb begin
    state_nx_s      = state_r;
    erase_cnt_nx_s  = erase_cnt_r;
    expose_len_nx_s = expose_len_r;
    expose_cnt_nx_s = expose_cnt_r;
    counter_nx_s    = counter_r;
    row_nx_s        = row_r;
    frame_done_nx_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        erase_cnt_nx_s  = {ERASE_W{1'b0}};
        expose_cnt_nx_s = {EXPOSE_BITS{1'b0}};
        counter_nx_s    = {PIXEL_BITS{1'b0}};
        row_nx_s        = {ROW_W{1'b0}};
        if (start) begin
          // A zero exposure still gets one expose cycle
          expose_len_nx_s = (expose_time == {EXPOSE_BITS{1'b0}}) ? EXP_ONE : expose_time;
          state_nx_s      = ST_ERASE;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ERASE: begin
        if (erase_cnt_r == ERASE_LAST) begin
          state_nx_s = ST_EXPOSE;
        end else begin
          erase_cnt_nx_s = erase_cnt_r + ERASE_ONE;
        end
      end
      ST_EXPOSE: begin
        if (expose_cnt_r == (expose_len_r - EXP_ONE)) begin
          state_nx_s = ST_CONVERT;
        end else begin
          expose_cnt_nx_s = expose_cnt_r + EXP_ONE;
        end
      end
      ST_CONVERT: begin
        // Counter saturates at max and holds there through readout
        if (counter_r == CNT_MAX) begin
          state_nx_s = ST_READ_SETUP;
          row_nx_s   = {ROW_W{1'b0}};
        end else begin
          counter_nx_s = counter_r + CNT_ONE;
        end
      end
      ST_READ_SETUP: begin
        state_nx_s = ST_READ_VALID;
      end
      ST_READ_VALID: begin
        if (row_ready) begin
          if (row_r == ROW_LAST) begin
            state_nx_s      = ST_IDLE;
            counter_nx_s    = {PIXEL_BITS{1'b0}};
            frame_done_nx_s = 1'b1;
          end else begin
            row_nx_s   = row_r + ROW_ONE;
            state_nx_s = ST_READ_SETUP;
          end
        end else begin
          state_nx_s = ST_READ_VALID;
        end
      end
      default: begin
        state_nx_s   = ST_IDLE;
        counter_nx_s = {PIXEL_BITS{1'b0}};
      end
    endcase
  end

  // Row enable decode from the upcoming state so outputs can be registered
  always_comb begin
    read_nx_s   = {ROWS{1'b0}};
    rd_active_s = (state_nx_s == ST_READ_SETUP) || (state_nx_s == ST_READ_VALID);
    for (int r = 0; r < ROWS; r++) begin
      read_nx_s[r] = rd_active_s && (row_nx_s == ROW_W'(r));
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      erase_cnt_r  <= {ERASE_W{1'b0}};
      expose_len_r <= {EXPOSE_BITS{1'b0}};
      expose_cnt_r <= {EXPOSE_BITS{1'b0}};
      counter_r    <= {PIXEL_BITS{1'b0}};
      row_r        <= {ROW_W{1'b0}};
      read_r       <= {ROWS{1'b0}};
      erase_r      <= 1'b0;
      expose_r     <= 1'b0;
      ramp_r       <= 1'b0;
      row_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      erase_cnt_r  <= erase_cnt_nx_s;
      expose_len_r <= expose_len_nx_s;
      expose_cnt_r <= expose_cnt_nx_s;
      counter_r    <= counter_nx_s;
      row_r        <= row_nx_s;
      read_r       <= read_nx_s;
      erase_r      <= (state_nx_s == ST_ERASE);
      expose_r     <= (state_nx_s == ST_EXPOSE);
      ramp_r       <= (state_nx_s == ST_CONVERT);
      row_valid_r  <= (state_nx_s == ST_READ_VALID);
      busy_r       <= (state_nx_s != ST_IDLE);
      frame_done_r <= frame_done_nx_s;
    end
  end

  assign erase      = erase_r;
  assign expose     = expose_r;
  assign ramp       = ramp_r;
  assign counter    = counter_r;
  assign read       = read_r;
  assign row_valid  = row_valid_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;

endmodule
